ahb_dma_copy: RTL
=================

# ahb_dma_copy

Single-channel AHB-Lite bus master that copies a block of 32-bit words from a source to a destination address range, one word at a time. It sits directly upstream of the AHB-Lite on-chip memory slave, through the bus decoder/mux, and is used to preload, move or clear-by-copy memory contents without processor involvement. Configuration arrives on sideband ports. Completion and error status are reported on level and pulse outputs.

## Interface

Parameters:

- LENWIDTH, 12: width of the word-count input; maximum transfer is 2^LENWIDTH-1 words.

Ports:

- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored, treated as 00.
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len  in  LENWIDTH  number of words to copy.
- busy  out  1  high from the cycle after start is accepted until the done cycle.
- done  out  1  one-cycle pulse at completion or abort.
- error  out  1  sticky; set on an HRESP error; cleared when the next start is accepted.
- words_done  out  LENWIDTH  count of words whose write data phase has completed.
- HADDR  out  32  AHB address.
- HTRANS  out  2  only 2'b00 (IDLE) or 2'b10 (NONSEQ) is driven.
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-ready from the bus.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

## Operation

- States: IDLE, RD_A, RD_D, WR_A, WR_D, DONE.
- IDLE:
  - On start with len≠0: latch src/dst (low 2 bits zeroed) and len; clear error and words_done; go to RD_A.
  - On start with len=0: go to DONE; no bus traffic.
  - start received in any other state is ignored.
- RD_A:
  - Drive HTRANS=NONSEQ, HWRITE=0, HADDR=src.
  - If a write data phase is pending (wr_pend), also drive HWDATA=buf in the same cycle. This overlaps the read address phase with the previous write's data phase.
  - On HREADY: clear wr_pend, increment words_done if wr_pend was set, go to RD_D.
- RD_D:
  - Drive HTRANS=IDLE.
  - On HREADY with HRESP=0: buf←HRDATA, src←src+4, go to WR_A.
- WR_A:
  - Drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst.
  - On HREADY: dst←dst+4, remaining←remaining-1, set wr_pend.
  - Next state is RD_A if remaining-1≠0, otherwise WR_D.
- WR_D:
  - Drive HTRANS=IDLE and HWDATA=buf.
  - On HREADY: increment words_done, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Addresses increment modulo 2^32 and wrap silently.
- Wait states: while HREADY=0, every output, state and counter holds.
- Error handling:
  - HREADY=0 with HRESP=1 marks the first error cycle. The next cycle must drive HTRANS=IDLE, cancelling any overlapped RD_A.
  - Set error and go to DONE without incrementing words_done.
  - A read error aborts before the write; a write error aborts the remaining words.

## Timing

- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, words_done=0; state=IDLE, wr_pend=0.
- The first NONSEQ is driven in the cycle after the edge that samples start.
- Zero-wait throughput is 3 cycles per word plus 1 trailing WR_D cycle, so a len=N copy takes 3N+1 bus cycles.
- done pulses in cycle 3N+2 after the start edge; busy is high during cycles 1..3N+1.
- For len=0, done pulses in the cycle after start, and busy stays 0.
- HWDATA stays stable throughout every write data phase, including any wait states.
- Reset asserted mid-transfer returns the block to IDLE immediately and drives HTRANS=IDLE. The partial copy is not resumed.

## Test plan

- len=1, src=0x0000_0000 holding 0xDEADBEEF, dst=0x0000_0100, zero wait:
  - HTRANS is NONSEQ at cycles 1 and 3; HWDATA=0xDEADBEEF at cycle 4.
  - done at cycle 5; memory[0x100]=0xDEADBEEF; words_done=1.
- len=4, src=0x0, dst=0x200:
  - Words copied in order; done at cycle 14; words_done=4.
  - RD_A overlaps the previous write data phase (NONSEQ read while HWDATA is valid).
- Insert 2 wait states on every data phase:
  - Address, control and HWDATA are held while HREADY=0.
  - Correct data is copied; total cycle count grows by exactly 2 per data phase.
- Two-cycle ERROR response on the 2nd write:
  - HTRANS=IDLE in the second error cycle.
  - error=1, words_done=1, done pulses; the next start clears error.
- len=0, and start while busy:
  - len=0: done the next cycle with no NONSEQ.
  - start pulses during busy change nothing.
- Mid-transfer HRESETn low, and src=0xFFFF_FFFC with len=2:
  - Reset: all outputs return to reset values asynchronously.
  - Wrap case: the second read address is 0x0000_0000.

Source files
------------

// File: rtl/ahb_dma_copy.sv
// Single-channel AHB-Lite copy engine: reads one word, writes it, repeats.
// The read address phase of the next word overlaps the previous write's data phase.
module ahb_dma_copy #(
    parameter int LENWIDTH = 12
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LENWIDTH-1:0] len,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [LENWIDTH-1:0] words_done,
    output logic [31:0]         HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic                HMASTLOCK,
    output logic [31:0]         HWDATA,
    input  logic [31:0]         HRDATA,
    input  logic                HREADY,
    input  logic                HRESP
);

    // state  | meaning
    // IDLE   | waiting for start
    // RD_A   | read address phase (may carry previous write data phase)
    // RD_D   | read data phase
    // WR_A   | write address phase
    // WR_D   | final write data phase
    // DONE   | one-cycle completion/abort pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D,
        S_DONE
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t state, state_nxt;

    logic [31:0]         src_q, dst_q, buf_q;
    logic [LENWIDTH-1:0] remaining_q, words_done_q;
    logic                wr_pend_q, err_cyc_q, error_q;

    logic in_dphase, abort;
    logic ld_cfg, rd_ok, wr_acc, inc_wd, clr_pend;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_cfg    = 1'b0;
        rd_ok     = 1'b0;
        wr_acc    = 1'b0;
        inc_wd    = 1'b0;
        clr_pend  = 1'b0;
        in_dphase = (state == S_RD_D) || (state == S_WR_D) ||
                    ((state == S_RD_A) && wr_pend_q);
        // second cycle of a two-cycle ERROR response ends the transfer
        abort     = in_dphase && HREADY && HRESP;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ld_cfg    = 1'b1;
                    state_nxt = (len == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (HREADY) begin
                    inc_wd    = wr_pend_q;
                    clr_pend  = 1'b1;
                    state_nxt = S_RD_D;
                end
            end
            S_RD_D: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (HREADY) begin
                    rd_ok     = 1'b1;
                    state_nxt = S_WR_A;
                end
            end
            S_WR_A: begin
                if (HREADY) begin
                    wr_acc    = 1'b1;
                    state_nxt = (remaining_q == LENWIDTH'(1)) ? S_WR_D : S_RD_A;
                end
            end
            S_WR_D: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (HREADY) begin
                    inc_wd    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            src_q        <= '0;
            dst_q        <= '0;
            buf_q        <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            wr_pend_q    <= 1'b0;
            err_cyc_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            err_cyc_q <= in_dphase && HRESP && !HREADY;
            if (ld_cfg) begin
                src_q        <= src_addr & 32'hFFFF_FFFC;
                dst_q        <= dst_addr & 32'hFFFF_FFFC;
                remaining_q  <= len;
                words_done_q <= '0;
                error_q      <= 1'b0;
                wr_pend_q    <= 1'b0;
            end
            if (rd_ok) begin
                buf_q <= HRDATA;
                src_q <= src_q + 32'd4;
            end
            if (wr_acc) begin
                dst_q       <= dst_q + 32'd4;
                remaining_q <= remaining_q - LENWIDTH'(1);
                wr_pend_q   <= 1'b1;
            end
            if (clr_pend || abort) wr_pend_q <= 1'b0;
            if (inc_wd) words_done_q <= words_done_q + LENWIDTH'(1);
            if (abort) error_q <= 1'b1;
        end
    end

    // an overlapped read address is withdrawn once an error response has begun
    assign HTRANS    = (((state == S_RD_A) && !err_cyc_q) || (state == S_WR_A)) ? TR_NONSEQ : TR_IDLE;
    assign HADDR     = (state == S_WR_A) ? dst_q : src_q;
    assign HWRITE    = (state == S_WR_A);
    assign HWDATA    = (((state == S_RD_A) && wr_pend_q) || (state == S_WR_D)) ? buf_q : 32'd0;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    assign busy       = (state == S_RD_A) || (state == S_RD_D) ||
                        (state == S_WR_A) || (state == S_WR_D);
    assign done       = (state == S_DONE);
    assign error      = error_q;
    assign words_done = words_done_q;

endmodule
